iir_coeff_bank: RTL
===================

# iir_coeff_bank

Double-buffered coefficient controller for the feed-forward stage of the configurable IIR filter. It accepts coefficient writes from a host or register interface into a shadow bank. It commits the shadow bank to the active bank atomically on a sample boundary, so the filter never runs with a half-updated coefficient set. The active bank drives the feed-forward stage's packed b-coefficient input directly.

## Interface
- `N`, 4, number of taps / coefficients
- `COEFF_WIDTH`, 16, signed coefficient width
- `ADDR_WIDTH`, 2, coefficient index width; must satisfy 2^ADDR_WIDTH >= N
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wr_valid`  in  1  coefficient write request
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`
- `wr_addr`  in  ADDR_WIDTH  coefficient index
- `wr_data`  in  COEFF_WIDTH  signed coefficient value
- `commit`  in  1  pulse; arms shadow->active transfer
- `abort`  in  1  pulse; cancels an armed commit
- `sample_en`  in  1  sample strobe, same strobe that clocks the filter datapath
- `packed_b_coeffs`  out  COEFF_WIDTH*N  active bank, b[t] at bits [COEFF_WIDTH*t +: COEFF_WIDTH]
- `armed`  out  1  commit pending
- `swap_done`  out  1  one-cycle pulse after the active bank is updated
- `err`  out  1  one-cycle pulse on a rejected operation

## Operation
- Two banks, each N x COEFF_WIDTH: shadow (written) and active (output).
- FSM states:
  - IDLE
    - `wr_ready`=1.
    - An accepted write with `wr_addr < N` updates `shadow[wr_addr]`.
    - `wr_addr >= N`: the write is dropped, and `err` pulses.
    - `commit` -> ARMED.
  - ARMED
    - `wr_ready`=0.
    - `sample_en` -> copy the whole shadow bank to the active bank, pulse `swap_done`, -> IDLE.
    - `abort` -> IDLE with no copy.
    - `commit` is rejected with an `err` pulse.
- The shadow bank is not cleared on swap. A partial update therefore rewrites only the changed taps.
- Same-cycle events:
  - Write and `commit` in IDLE: the write lands, then the FSM arms.
  - `commit` and `sample_en` in IDLE: the FSM arms; the swap happens on a later `sample_en`.
  - `abort` and `sample_en` in ARMED: `abort` wins and no swap occurs.
  - `abort` in IDLE: ignored, no error.
- Reset:
  - Both banks are set to 0, so the filter outputs 0.
  - FSM -> IDLE.
  - Reset mid-ARMED discards the pending commit.

## Timing
- Reset values:
  - `packed_b_coeffs`=0
  - `armed`=0
  - `swap_done`=0
  - `err`=0
  - `wr_ready`=1 (combinational from the FSM state)
- Shadow write latency: 1 cycle after the handshake.
- Commit: `armed` rises the cycle after the edge that samples `commit`.
- Swap: `packed_b_coeffs` changes on the edge that samples `sample_en` in ARMED. On the same edge, `armed` falls and `swap_done` rises for exactly 1 cycle.
- `packed_b_coeffs` is fully registered; no combinational path from any input.
- `err` is registered, asserted 1 cycle after the offending input, for 1 cycle.

## Configuration
- `IIR_COEFF_READBACK_EN`
  - Defined:
    - Adds inputs `rd_addr` [ADDR_WIDTH] and output `rd_data` [COEFF_WIDTH].
    - `rd_data` is the registered `shadow[rd_addr]`, 1-cycle latency.
    - `rd_addr >= N` returns 0.
  - Undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared IIR package holds:
  - the FSM state encoding (IDLE, ARMED);
  - default N and COEFF_WIDTH constants, also used by the feed-forward stage;
  - the packing helper macro/function for the b[t] bit slice.
- No sub-module needed. Bank storage is inline register arrays with a generate loop per tap.

## Test plan
- Reset then idle: `packed_b_coeffs`=0, `wr_ready`=1, no `err`/`swap_done` after 20 cycles.
- Write b={0x0100, 0x0080, 0x0040, 0x0020}, then `commit`, `sample_en` 5 cycles later:
  - output unchanged until that edge;
  - then equals `{0x0020, 0x0040, 0x0080, 0x0100}` (b[3] in the MSBs);
  - `swap_done` high 1 cycle.
- Partial update: after the previous test, write only b[2]=0xFFC0, commit, swap -> output b = {0x0100, 0x0080, 0xFFC0, 0x0020}.
- Same-cycle `commit` + `sample_en` in IDLE:
  - no swap that cycle;
  - `armed`=1;
  - swap on the next `sample_en`.
- Errors:
  - write to `wr_addr`=N with ADDR_WIDTH=3, N=4 -> `err` pulse, shadow unchanged;
  - `commit` while ARMED -> `err` pulse, state stays ARMED;
  - `abort` + `sample_en` same cycle -> IDLE, no swap.
- Assert `rst` asynchronously mid-ARMED (between clock edges):
  - outputs clear immediately;
  - after release, `sample_en` causes no swap and `packed_b_coeffs`=0.

Source files
------------

// File: rtl/iir_coeff_bank_pkg.sv
// Shared IIR definitions: default tap count and coefficient width, the coefficient
// bank FSM state type, and the b[t] bit-slice helper used by the packed bus.
package iir_coeff_bank_pkg;

  localparam int unsigned IIR_N           = 4;
  localparam int unsigned IIR_COEFF_WIDTH = 16;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } iir_bank_state_t;

  // LSB position of b[t] within the packed coefficient bus.
  function automatic int unsigned iir_b_lsb(input int unsigned t, input int unsigned width);
    return t * width;
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// Double-buffered b-coefficient bank: host writes go to a shadow bank, which is copied
// atomically to the active bank on a sample strobe. Optional readback: IIR_COEFF_READBACK_EN.
module iir_coeff_bank
  import iir_coeff_bank_pkg::*;
#(
  parameter int unsigned N           = IIR_N,
  parameter int unsigned COEFF_WIDTH = IIR_COEFF_WIDTH,
  parameter int unsigned ADDR_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [COEFF_WIDTH-1:0]   wr_data,
  input  logic                     commit,
  input  logic                     abort,
  input  logic                     sample_en,
  output logic [COEFF_WIDTH*N-1:0] packed_b_coeffs,
  output logic                     armed,
  output logic                     swap_done,
`ifdef IIR_COEFF_READBACK_EN
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [COEFF_WIDTH-1:0]   rd_data,
`endif
  output logic                     err
);

  localparam logic [ADDR_WIDTH:0] LP_N = (ADDR_WIDTH + 1)'(N);

  iir_bank_state_t            r_state;
  logic                       r_armed;
  logic                       r_swap_done;
  logic                       r_err;
  logic                       w_wr_fire;
  logic                       w_wr_in_range;
  logic                       w_swap;
  logic [COEFF_WIDTH*N-1:0]   w_shadow_flat;

  assign wr_ready      = (r_state == ST_IDLE);
  assign w_wr_fire     = wr_valid & wr_ready;
  assign w_wr_in_range = ({1'b0, wr_addr} < LP_N);
  // abort outranks a coincident sample strobe
  assign w_swap        = (r_state == ST_ARMED) & sample_en & ~abort;

  assign armed     = r_armed;
  assign swap_done = r_swap_done;
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b0;
      r_swap_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_err <= w_wr_fire & ~w_wr_in_range;
          if (commit) begin
            r_state <= ST_ARMED;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          r_err <= commit;
          if (abort) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end else if (sample_en) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_swap_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  for (genvar t = 0; t < N; t++) begin : g_tap
    logic [COEFF_WIDTH-1:0] r_shadow;
    logic [COEFF_WIDTH-1:0] r_active;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_shadow <= '0;
        r_active <= '0;
      end else begin
        if (w_wr_fire && w_wr_in_range && (wr_addr == ADDR_WIDTH'(t)))
          r_shadow <= wr_data;
        if (w_swap)
          r_active <= r_shadow;
      end
    end

    assign w_shadow_flat[iir_b_lsb(t, COEFF_WIDTH) +: COEFF_WIDTH]   = r_shadow;
    assign packed_b_coeffs[iir_b_lsb(t, COEFF_WIDTH) +: COEFF_WIDTH] = r_active;
  end

`ifdef IIR_COEFF_READBACK_EN
  logic [COEFF_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rd_data <= '0;
    else if ({1'b0, rd_addr} < LP_N)
      r_rd_data <= w_shadow_flat[32'(rd_addr) * COEFF_WIDTH +: COEFF_WIDTH];
    else
      r_rd_data <= '0;
  end

  assign rd_data = r_rd_data;
`endif

endmodule
